// File: rtl/cfg_pkg.sv
// Shared types and sizing helpers for the configuration chain loader.
package cfg_pkg;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   localparam int unsigned DEF_CHAIN_LEN = 69;

   function automatic int unsigned num_words(input int unsigned chain_len, input int unsigned word_w);
      return (chain_len + word_w - 1) / word_w;
   endfunction

   function automatic int unsigned cnt_w(input int unsigned max_val);
      return $clog2(max_val + 1);
   endfunction

   localparam int unsigned BIT_CNT_W = cnt_w(DEF_CHAIN_LEN);

endpackage

// File: rtl/cfg_word_buf.sv
// Two-deep word buffer (shift register + pending word) serialising words LSB first.
module cfg_word_buf #(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned LEFT_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              load,
   input  logic [WORD_W-1:0] data,
   input  logic [LEFT_W-1:0] nbits,
   output logic              prog_in,
   output logic              prog_en,
   output logic              pend_vld
);

   logic [WORD_W-1:0] sr;
   logic [WORD_W-1:0] pend;
   logic [WORD_W-1:0] sr_shift;
   logic [LEFT_W-1:0] sr_left;
   logic [LEFT_W-1:0] pend_left;
   logic              sr_free;

   assign sr_shift = sr >> 1;
   // sr_left==1 always coincides with prog_en=1, so sr can take a new word this edge
   assign sr_free  = (sr_left == '0) || (sr_left == LEFT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr        <= '0;
         pend      <= '0;
         sr_left   <= '0;
         pend_left <= '0;
         pend_vld  <= 1'b0;
         prog_in   <= 1'b0;
         prog_en   <= 1'b0;
      end else if (clr) begin
         sr        <= '0;
         pend      <= '0;
         sr_left   <= '0;
         pend_left <= '0;
         pend_vld  <= 1'b0;
         prog_en   <= 1'b0;
      end else if (!sr_free) begin
         sr      <= sr_shift;
         sr_left <= sr_left - LEFT_W'(1);
         prog_in <= sr_shift[0];
         prog_en <= 1'b1;
         if (load) begin
            pend      <= data;
            pend_left <= nbits;
            pend_vld  <= 1'b1;
         end
      end else if (pend_vld) begin
         sr       <= pend;
         sr_left  <= pend_left;
         prog_in  <= pend[0];
         prog_en  <= 1'b1;
         pend_vld <= 1'b0;
      end else if (load) begin
         sr      <= data;
         sr_left <= nbits;
         prog_in <= data[0];
         prog_en <= 1'b1;
      end else begin
         // stall: prog_in keeps the last bit driven
         sr_left <= '0;
         prog_en <= 1'b0;
      end
   end

endmodule

// File: rtl/cfg_chain_loader.sv
// Loads a parallel-word bitstream onto the serial configuration chain, LSB of word 0 first.
module cfg_chain_loader #(
   parameter int unsigned CHAIN_LEN = 69,
   parameter int unsigned WORD_W    = 32
) (
   input  logic                           prog_clk,
   input  logic                           prog_rst_n,
   input  logic                           start,
   input  logic                           abort,
   input  logic [WORD_W-1:0]              cfg_data,
   input  logic                           cfg_valid,
   output logic                           cfg_ready,
   output logic                           prog_in,
   output logic                           prog_en,
   output logic                           busy,
   output logic                           done,
   output logic [$clog2(CHAIN_LEN+1)-1:0] bits_sent
);
   import cfg_pkg::*;

   localparam int unsigned NUM_WORDS = num_words(CHAIN_LEN, WORD_W);
   localparam int unsigned WORDS_W   = cnt_w(NUM_WORDS);
   localparam int unsigned LEFT_W    = cnt_w(WORD_W);
   localparam int unsigned BITS_W    = cnt_w(CHAIN_LEN);

   state_t             state;
   state_t             state_n;
   logic [WORDS_W-1:0] words_acc;
   logic [LEFT_W-1:0]  nbits;
   logic               pend_vld;
   logic               xfer;
   logic               clr;
   logic               begin_load;
   logic               shift;
   int unsigned        rem;

   assign cfg_ready  = (state == RUN) && (words_acc < WORDS_W'(NUM_WORDS)) && !pend_vld;
   assign xfer       = cfg_valid && cfg_ready && !abort;
   assign clr        = (state == RUN) && abort;
   assign begin_load = (state == IDLE) && start && !abort;
   assign shift      = prog_en && (state == RUN) && !abort;

   // the final word may be partial; its upper bits never reach prog_in
   always_comb begin
      rem   = CHAIN_LEN - WORD_W * 32'(words_acc);
      nbits = (rem >= WORD_W) ? LEFT_W'(WORD_W) : LEFT_W'(rem);
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (begin_load) state_n = RUN;
         RUN:     if (abort) state_n = IDLE;
                  else if (shift && bits_sent == BITS_W'(CHAIN_LEN - 1)) state_n = FIN;
         FIN:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) state <= IDLE;
      else             state <= state_n;
   end

   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         words_acc <= '0;
         bits_sent <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         busy <= (state_n == RUN);
         done <= (state_n == FIN);
         if (begin_load) begin
            words_acc <= '0;
            bits_sent <= '0;
         end else begin
            if (xfer)  words_acc <= words_acc + WORDS_W'(1);
            if (shift) bits_sent <= bits_sent + BITS_W'(1);
         end
      end
   end

   cfg_word_buf #(
      .WORD_W (WORD_W),
      .LEFT_W (LEFT_W)
   ) u_buf (
      .clk      (prog_clk),
      .rst_n    (prog_rst_n),
      .clr      (clr),
      .load     (xfer),
      .data     (cfg_data),
      .nbits    (nbits),
      .prog_in  (prog_in),
      .prog_en  (prog_en),
      .pend_vld (pend_vld)
   );

endmodule

// File: doc/cfg_chain_loader.md
# cfg_chain_loader

Configuration chain loader: the stage directly upstream of the connection-box / CLB programming chain. It accepts the bitstream as parallel words over a valid/ready stream and shifts it, LSB first, onto the chain's serial `prog_in`/`prog_en` pins. Bit 0 of word 0 is the first bit driven, matching the chain's `prog[0]`-first load order. It tolerates stalls, supports abort, and signals completion once exactly `CHAIN_LEN` bits have been shifted.

## Interface
- `CHAIN_LEN`, 69: total chain bits to shift per load (≥1).
- `WORD_W`, 32: input word width (≥1). NUM_WORDS = ceil(CHAIN_LEN/WORD_W).
- `prog_clk`  in  1  configuration clock; all logic on posedge.
- `prog_rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a load; honoured only in IDLE.
- `abort`  in  1  terminate the load in progress.
- `cfg_data`  in  WORD_W  bitstream word; bit 0 is shifted first.
- `cfg_valid`  in  1  `cfg_data` is valid.
- `cfg_ready`  out  1  the loader accepts the word this cycle.
- `prog_in`  out  1  serial bit to the chain.
- `prog_en`  out  1  chain shift enable; the chain samples `prog_in` on posedge while this is high.
- `busy`  out  1  a load is in progress.
- `done`  out  1  one-cycle pulse when the load completes.
- `bits_sent`  out  $clog2(CHAIN_LEN+1)  bits shifted so far in the current load.

## Operation
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1.
  - FIN: a one-cycle `done` state that returns to IDLE.
- IDLE → RUN on `start`=1. `start` in RUN or FIN is ignored.
- Buffering is two-deep:
  - Shift register `sr` has a count `sr_left`.
  - Pending register `pend` has a flag `pend_vld`.
- `cfg_ready` = RUN && `words_accepted` < NUM_WORDS && !`pend_vld`. A transfer occurs on `cfg_valid && cfg_ready`.
- On a transfer:
  - The word loads into `sr` if `sr` is empty, or is emptying this cycle (`sr_left`==1 and `prog_en`=1). Otherwise it loads into `pend`.
  - When `sr` empties and `pend_vld`=1, `pend` moves into `sr` on the same edge.
- Bits per word = min(WORD_W, CHAIN_LEN − WORD_W·index). Upper bits of the final partial word are never driven.
- Shifting:
  - While `sr_left`>0, `prog_en`=1 and `prog_in`=`sr[0]`.
  - Each edge shifts `sr` right, decrements `sr_left` and increments `bits_sent`.
- Stall: if `sr` empties with no word available, `prog_en`=0 and `prog_in` holds its last value. No bit is lost or repeated.
- Completion:
  - When `bits_sent` reaches CHAIN_LEN, go to FIN.
  - In FIN: `prog_en`=0, `done`=1, `busy`=0.
  - Then IDLE. `bits_sent` holds CHAIN_LEN until the next `start`, which clears it.
- Words offered after NUM_WORDS have been accepted are not accepted (`cfg_ready`=0).
- `abort` in RUN:
  - Next edge → IDLE.
  - `prog_en`=0, `sr`/`pend` cleared, no `done`, `bits_sent` holds its partial count.
  - `abort` has priority over a same-cycle transfer; that word is dropped.
  - `abort` and `start` together in IDLE: `start` is ignored.
- Reset (asynchronous, any time including mid-shift):
  - IDLE.
  - `prog_en`=0, `prog_in`=0, `cfg_ready`=0, `busy`=0, `done`=0, `bits_sent`=0.
  - Buffers cleared.

## Timing
- All outputs are registered except `cfg_ready`, which is decoded from registered state.
- Cycle numbering:
  - `start` sampled at edge E0 → RUN, with `cfg_ready`=1 during cycle 1.
  - First word accepted at edge E1 → bit 0 driven during cycle 2 (`prog_en`=1).
- With no stalls and every word offered on time, bits are driven contiguously in cycles 2…CHAIN_LEN+1, and `done` is high in cycle CHAIN_LEN+2.
  - Default parameters: 69 bits contiguous, `done` at cycle 71.
- Word boundaries are gapless whenever the next word was accepted no later than the edge on which the current word's last bit is driven.
- A word accepted at edge Ek into an empty `sr` drives its bit 0 in cycle k+1.

## Structure
- Shared package `cfg_pkg`:
  - State enum {IDLE, RUN, FIN}.
  - Function `num_words(chain_len, word_w)`.
  - Localparam `BIT_CNT_W`.
- Sub-module `cfg_word_buf` holds `sr`/`pend`, the per-word bit count and the load/advance logic.
- The top level holds the FSM, word and bit counters, and the handshake.

## Test plan
- Full load, defaults:
  - Random 69-bit vector, 3 words, `cfg_valid` held high.
  - The loader drives an instantiated CBModule chain.
  - Required response: the chain contents equal the vector; `prog_en` high for exactly cycles 2–70; `done` a single pulse at cycle 71.
- Backpressure:
  - Hold `cfg_valid` low for 5 cycles before word 1 and 3 cycles before word 2.
  - Required response: `prog_en` low exactly during the gaps; the serial stream equals the vector with no duplicated or dropped bits; `bits_sent`=69 at `done`.
- Abort:
  - Assert `abort` when `bits_sent`=40.
  - Required response: next cycle IDLE, `prog_en`=0, no `done`, `bits_sent`=40.
  - A following `start` plus a full load then succeeds.
- Start while busy and excess words:
  - Pulse `start` at `bits_sent`=10 and offer a 4th word after 3 have been accepted.
  - Required response: both are ignored; the load completes normally and `cfg_ready` stays 0 after word 3.
- Reset mid-shift:
  - Drive `prog_rst_n` low at `bits_sent`=33, asynchronously between edges.
  - Required response: all outputs go to their reset values immediately; after release, a new load works.
- Exact multiple:
  - `CHAIN_LEN`=64, `WORD_W`=32.
  - Required response: 2 words, 64 contiguous bits, `done` at cycle 66; with `CHAIN_LEN`=69, upper bits 5–31 of word 2 never appear on `prog_in`.
